// File: rtl/chain_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | chain_sched_if : control, read-triple and write-back bundle of chain_sched |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface chain_sched_if;
   logic       start;
   logic [7:0] matlen;
   logic       busy;
   logic       done;
   logic       err;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] ir;
   logic [7:0] kr;
   logic [7:0] jr;
   logic       last_k;
   logic       rw;
   logic       winit;
   logic [7:0] iw;
   logic [7:0] jw;

   modport master (
      input  start, matlen, rd_ready,
      output busy, done, err, rd_valid, ir, kr, jr, last_k, rw, winit, iw, jw
   );

   modport slave (
      output start, matlen, rd_ready,
      input  busy, done, err, rd_valid, ir, kr, jr, last_k, rw, winit, iw, jw
   );
endinterface
`default_nettype wire

// File: rtl/chain_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | chain_sched : diagonal-order sequencer for the matrix-chain DP table       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module chain_sched #(
   parameter int N_MAX = 32,
   parameter int LAT   = 2
) (
   input  wire logic     clk,
   input  wire logic     reset,
   chain_sched_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [7:0] C_N_MAX     = 8'(N_MAX);
   localparam logic [3:0] C_LAT_LAST  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
   localparam bit         C_HAS_DRAIN = (LAT > 0);

   logic [2:0] r_state, w_state_nx;
   logic [7:0] r_n, w_n_nx;
   logic [7:0] r_i, w_i_nx;
   logic [7:0] r_k, w_k_nx;
   logic [7:0] r_d, w_d_nx;
   logic [3:0] r_cnt, w_cnt_nx;
   logic       r_err, w_err_nx;

   logic       r_busy, r_done, r_rd_valid, r_last_k, r_rw, r_winit;
   logic [7:0] r_ir, r_kr, r_jr, r_iw, r_jw;
   logic       w_busy_nx, w_done_nx, w_rd_valid_nx, w_last_k_nx, w_rw_nx, w_winit_nx;
   logic [7:0] w_j_nx;

   logic [7:0] w_j;
   logic       w_hs;

   assign w_j  = r_i + r_d;
   assign w_hs = r_rd_valid & bus.rd_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_n        <= 8'd0;
         r_i        <= 8'd0;
         r_k        <= 8'd0;
         r_d        <= 8'd0;
         r_cnt      <= 4'd0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_last_k   <= 1'b0;
         r_rw       <= 1'b0;
         r_winit    <= 1'b0;
         r_ir       <= 8'd0;
         r_kr       <= 8'd0;
         r_jr       <= 8'd0;
         r_iw       <= 8'd0;
         r_jw       <= 8'd0;
      end else begin
         r_state    <= w_state_nx;
         r_n        <= w_n_nx;
         r_i        <= w_i_nx;
         r_k        <= w_k_nx;
         r_d        <= w_d_nx;
         r_cnt      <= w_cnt_nx;
         r_err      <= w_err_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_rd_valid <= w_rd_valid_nx;
         r_last_k   <= w_last_k_nx;
         r_rw       <= w_rw_nx;
         r_winit    <= w_winit_nx;
         r_ir       <= w_i_nx;
         r_kr       <= w_k_nx;
         r_jr       <= w_j_nx;
         r_iw       <= w_i_nx;
         r_jw       <= w_j_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_n_nx     = r_n;
      w_i_nx     = r_i;
      w_k_nx     = r_k;
      w_d_nx     = r_d;
      w_cnt_nx   = r_cnt;
      w_err_nx   = r_err;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_n_nx   = bus.matlen;
               w_err_nx = (bus.matlen > C_N_MAX);
               w_i_nx   = 8'd0;
               w_k_nx   = 8'd0;
               w_d_nx   = 8'd0;
               if ((bus.matlen == 8'd0) || (bus.matlen > C_N_MAX)) begin
                  w_state_nx = S_DONE;
               end else begin
                  w_state_nx = S_INIT;
               end
            end
         end
         S_INIT: begin
            if (r_i == r_n - 8'd1) begin
               w_i_nx     = 8'd0;
               w_k_nx     = 8'd0;
               w_d_nx     = 8'd1;
               w_state_nx = (r_n == 8'd1) ? S_DONE : S_ISSUE;
            end else begin
               w_i_nx = r_i + 8'd1;
            end
         end
         S_ISSUE: begin
            if (w_hs) begin
               w_k_nx = r_k + 8'd1;
               if (r_last_k) begin
                  w_cnt_nx   = 4'd0;
                  w_state_nx = C_HAS_DRAIN ? S_DRAIN : S_WRITE;
               end
            end
         end
         S_DRAIN: begin
            if (r_cnt == C_LAT_LAST) begin
               w_state_nx = S_WRITE;
            end else begin
               w_cnt_nx = r_cnt + 4'd1;
            end
         end
         S_WRITE: begin
            if (w_j < r_n - 8'd1) begin
               w_i_nx     = r_i + 8'd1;
               w_k_nx     = r_i + 8'd1;
               w_state_nx = S_ISSUE;
            end else if (r_d < r_n - 8'd1) begin
               w_d_nx     = r_d + 8'd1;
               w_i_nx     = 8'd0;
               w_k_nx     = 8'd0;
               w_state_nx = S_ISSUE;
            end else begin
               w_state_nx = S_DONE;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state values; d stays 0 during INIT so j = i+d
   // yields the diagonal address there without a separate mux.
   always_comb begin
      w_j_nx        = w_i_nx + w_d_nx;
      w_busy_nx     = (w_state_nx != S_IDLE);
      w_done_nx     = (w_state_nx == S_DONE);
      w_rd_valid_nx = (w_state_nx == S_ISSUE);
      w_last_k_nx   = w_rd_valid_nx && (w_k_nx == w_j_nx - 8'd1);
      w_rw_nx       = (w_state_nx == S_INIT) || (w_state_nx == S_WRITE);
      w_winit_nx    = (w_state_nx == S_INIT);
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.rd_valid = r_rd_valid;
   assign bus.last_k   = r_last_k;
   assign bus.ir       = r_ir;
   assign bus.kr       = r_kr;
   assign bus.jr       = r_jr;
   assign bus.rw       = r_rw;
   assign bus.winit    = r_winit;
   assign bus.iw       = r_iw;
   assign bus.jw       = r_jw;
endmodule
`default_nettype wire

// File: tb/tb_chain_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_chain_sched : directed scenarios against a loop-level schedule model    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_chain_sched;
   localparam int N_MAX = 32;
   localparam int MAXC  = 256;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   chain_sched_if bus_a ();
   chain_sched_if bus_b ();

   chain_sched #(.N_MAX(N_MAX), .LAT(2)) dut  (.clk(clk), .reset(reset), .bus(bus_a));
   chain_sched #(.N_MAX(N_MAX), .LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus_b));

   logic       sel = 1'b0;
   logic       active = 1'b0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic [6:0] of;
   logic [7:0] oir, okr, ojr, oiw, ojw;
   logic       ordy;

   // of = {busy, done, err, rd_valid, last_k, rw, winit}
   always_comb begin
      if (sel) begin
         of  = {bus_b.busy, bus_b.done, bus_b.err, bus_b.rd_valid, bus_b.last_k, bus_b.rw, bus_b.winit};
         oir = bus_b.ir; okr = bus_b.kr; ojr = bus_b.jr; oiw = bus_b.iw; ojw = bus_b.jw;
         ordy = bus_b.rd_ready;
      end else begin
         of  = {bus_a.busy, bus_a.done, bus_a.err, bus_a.rd_valid, bus_a.last_k, bus_a.rw, bus_a.winit};
         oir = bus_a.ir; okr = bus_a.kr; ojr = bus_a.jr; oiw = bus_a.iw; ojw = bus_a.jw;
         ordy = bus_a.rd_ready;
      end
   end

   logic [6:0] e_f [MAXC];
   logic [7:0] e_ir [MAXC], e_kr [MAXC], e_jr [MAXC], e_iw [MAXC], e_jw [MAXC];

   int wr_q[$], tr_q[$], lk_q[$], lkc_q[$], nw_q[$];
   int done_cyc;

   task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, req);
      end
   endtask

   function automatic bit ready(input int t, input int mode);
      return (mode == 0) ? 1'b1 : ((t % 2) == 0);
   endfunction

   function automatic int w3(input int c, input int i, input int j);
      return c * 65536 + i * 256 + j;
   endfunction

   // Schedule from the loop nest: diagonals d, cells i, splits k; stalls follow rd_ready.
   task automatic build_model(input int n, input int lat, input int mode, output int len);
      int  t;
      bit  acc;
      bit  e;
      for (int c = 0; c < MAXC; c++) begin
         e_f[c] = '0; e_ir[c] = '0; e_kr[c] = '0; e_jr[c] = '0; e_iw[c] = '0; e_jw[c] = '0;
      end
      e = (n > N_MAX);
      t = 1;
      if (n > 0 && !e) begin
         for (int i = 0; i < n; i++) begin
            e_f[t] = 7'b1000011; e_iw[t] = 8'(i); e_jw[t] = 8'(i); t++;
         end
         for (int d = 1; d < n; d++) begin
            for (int i = 0; i + d < n; i++) begin
               for (int k = i; k < i + d; k++) begin
                  do begin
                     e_f[t] = {3'b100, 1'b1, (k == i + d - 1), 2'b00};
                     e_ir[t] = 8'(i); e_kr[t] = 8'(k); e_jr[t] = 8'(i + d);
                     acc = ready(t, mode);
                     t++;
                  end while (!acc);
               end
               for (int l = 0; l < lat; l++) begin
                  e_f[t] = 7'b1000000; t++;
               end
               e_f[t] = 7'b1000010; e_iw[t] = 8'(i); e_jw[t] = 8'(i + d); t++;
            end
         end
      end
      e_f[t] = 7'b1100000;
      len = t;
      for (int c = 1; c <= len + 1; c++) e_f[c][4] = e;
   endtask

   always @(negedge clk) begin
      if (active && cyc >= 1 && cyc < MAXC) begin
         chk("flags", cyc, 64'(of), 64'(e_f[cyc]));
         if (e_f[cyc][3]) chk("triple", cyc, 64'({oir, okr, ojr}), 64'({e_ir[cyc], e_kr[cyc], e_jr[cyc]}));
         if (e_f[cyc][1]) chk("waddr", cyc, 64'({oiw, ojw}), 64'({e_iw[cyc], e_jw[cyc]}));
         if (of[1]) wr_q.push_back(w3(cyc, int'(oiw), int'(ojw)));
         if (of[1] && !of[0]) nw_q.push_back(cyc);
         if (of[3] && ordy) begin
            tr_q.push_back(w3(int'(oir), int'(okr), int'(ojr)));
            lk_q.push_back(int'(of[2]));
            if (of[2]) lkc_q.push_back(cyc);
         end
         if (of[5]) done_cyc = cyc;
      end
   end

   task automatic set_start(input bit use_b, input logic v);
      if (use_b) bus_b.start = v; else bus_a.start = v;
   endtask

   task automatic run(input bit use_b, input int n, input int mode, input bit hold, input int abort_at);
      int len;
      build_model(n, use_b ? 0 : 2, mode, len);
      wr_q.delete(); tr_q.delete(); lk_q.delete(); lkc_q.delete(); nw_q.delete();
      done_cyc = -1;
      @(posedge clk); #1;
      sel = use_b; cyc = 0;
      bus_a.matlen = 8'(n); bus_b.matlen = 8'(n);
      set_start(use_b, 1'b1);
      bus_a.rd_ready = ready(0, mode); bus_b.rd_ready = ready(0, mode);
      active = 1'b1;
      while (cyc < len + 1) begin
         @(posedge clk); #1;
         cyc++;
         bus_a.rd_ready = ready(cyc, mode); bus_b.rd_ready = ready(cyc, mode);
         if (!hold || cyc >= len + 1) set_start(use_b, 1'b0);
         if (hold) begin bus_a.matlen = 8'd7; bus_b.matlen = 8'd7; end
         if (cyc == abort_at) begin
            active = 1'b0;
            #2 reset = 1'b0;
            #1 chk("abort_outputs", cyc, {17'd0, of, oir, okr, ojr, oiw, ojw}, 64'd0);
            repeat (3) begin
               @(negedge clk);
               chk("abort_quiet", cyc, 64'({of[6], of[3], of[1]}), 64'd0);
            end
            reset = 1'b1;
            return;
         end
      end
      @(negedge clk); #1;
      active = 1'b0;
   endtask

   task automatic chk_q(input string name, input int got[$], input int want[$]);
      chk({name, "_count"}, 0, 64'(got.size()), 64'(want.size()));
      for (int idx = 0; idx < want.size() && idx < got.size(); idx++)
         chk(name, idx, 64'(got[idx]), 64'(want[idx]));
   endtask

   initial begin
      int q3w[$], q3t[$], q3l[$];
      bus_a.start = 1'b0; bus_a.matlen = 8'd0; bus_a.rd_ready = 1'b1;
      bus_b.start = 1'b0; bus_b.matlen = 8'd0; bus_b.rd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("reset_a", 0, {17'd0, of, oir, okr, ojr, oiw, ojw}, 64'd0);
      sel = 1'b1;
      #1 chk("reset_b", 0, {17'd0, of, oir, okr, ojr, oiw, ojw}, 64'd0);
      sel = 1'b0;
      @(negedge clk) reset = 1'b1;

      q3w = '{w3(1,0,0), w3(2,1,1), w3(3,2,2), w3(7,0,1), w3(11,1,2), w3(16,0,2)};
      q3t = '{w3(0,0,1), w3(1,1,2), w3(0,0,2), w3(0,1,2)};
      q3l = '{1, 1, 0, 1};

      run(1'b0, 3, 0, 1'b0, 0);
      chk_q("n3_writes", wr_q, q3w);
      chk_q("n3_triples", tr_q, q3t);
      chk_q("n3_lastk", lk_q, q3l);
      chk("n3_done", 0, 64'(done_cyc), 64'd17);

      run(1'b0, 1, 0, 1'b0, 0);
      chk_q("n1_writes", wr_q, '{w3(1,0,0)});
      chk("n1_triples", 0, 64'(tr_q.size()), 64'd0);
      chk("n1_done", 0, 64'(done_cyc), 64'd2);

      run(1'b0, 40, 0, 1'b0, 0);
      chk("n40_writes", 0, 64'(wr_q.size()), 64'd0);
      chk("n40_done", 0, 64'(done_cyc), 64'd1);

      run(1'b0, 0, 0, 1'b0, 0);
      chk("n0_writes", 0, 64'(wr_q.size()), 64'd0);
      chk("n0_done", 0, 64'(done_cyc), 64'd1);

      run(1'b0, 3, 0, 1'b1, 0);
      chk_q("rep_writes", wr_q, q3w);
      chk_q("rep_triples", tr_q, q3t);
      chk("rep_done", 0, 64'(done_cyc), 64'd17);

      run(1'b1, 4, 1, 1'b0, 0);
      chk("n4_triples", 0, 64'(tr_q.size()), 64'd10);
      chk("n4_writes", 0, 64'(wr_q.size()), 64'd10);
      chk("n4_cells", 0, 64'(lkc_q.size()), 64'd6);
      for (int idx = 0; idx < nw_q.size() && idx < lkc_q.size(); idx++)
         chk("n4_write_after_lastk", idx, 64'(nw_q[idx]), 64'(lkc_q[idx] + 1));

      run(1'b0, 5, 0, 1'b0, 6);
      @(negedge clk);
      chk("post_abort_idle", 0, 64'({of[6], of[3], of[1]}), 64'd0);

      run(1'b0, 2, 0, 1'b0, 0);
      chk_q("n2_writes", wr_q, '{w3(1,0,0), w3(2,1,1), w3(6,0,1)});
      chk_q("n2_triples", tr_q, '{w3(0,0,1)});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/chain_sched.md
# chain_sched

Clocked sequencer for the matrix-chain-multiplication dynamic-programming array. For a chain of `matlen` matrices it walks every table cell (i,j) in diagonal order. For each cell it issues one read triple (i,k,j) per split point k to the cost datapath, waits for the datapath's fixed pipeline latency, and then commands the write-back of cell (i,j). It sits between the top-level control (start/done) and the cost/min datapath and table memory, and replaces the unclocked loop-based index generation.

## Interface
- `N_MAX`, 32, largest accepted chain length (matrices); 2..255
- `LAT`, 2, datapath cycles from the last accepted triple to the min-result being ready for write-back; 0..15

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low forces all state and outputs to reset values
- `start`  in  1  begin a run; sampled only in IDLE
- `matlen`  in  8  chain length n; captured on the accepted start
- `busy`  out  1  high from the cycle after start through the DONE cycle
- `done`  out  1  one-cycle pulse ending a run
- `err`  out  1  set with done when n > N_MAX; cleared on next accepted start
- `rd_valid`  out  1  triple ir/kr/jr valid
- `rd_ready`  in  1  datapath accepts the triple when rd_valid & rd_ready
- `ir`, `kr`, `jr`  out  8 each  read triple: m[i][k], m[k+1][j]
- `last_k`  out  1  high with rd_valid when k = j-1
- `rw`  out  1  table write strobe, one cycle per cell
- `winit`  out  1  with rw: write zero (diagonal cell)
- `iw`, `jw`  out  8 each  write cell address; meaningful only when rw=1

## Operation
- Run states: IDLE, INIT, ISSUE, DRAIN, WRITE, DONE.
- **IDLE**
  - start=1: capture n=matlen.
  - n=0 or n>N_MAX → DONE (err=1 if n>N_MAX).
  - Otherwise → INIT with i=0.
- **INIT**
  - Each cycle: rw=1, winit=1, iw=jw=i; i++.
  - After i=n-1 → d=1, i=0. Go to DONE if n=1, otherwise ISSUE.
- **ISSUE**
  - j=i+d, k starts at i.
  - rd_valid=1 with ir=i, kr=k, jr=j, last_k=(k==j-1).
  - On handshake: k++.
  - On the handshake with last_k → DRAIN if LAT>0, else WRITE.
  - rd_ready low: hold rd_valid and all indices stable.
- **DRAIN**: count LAT cycles, then → WRITE.
- **WRITE**
  - One cycle: rw=1, winit=0, iw=i, jw=j.
  - Then if i+d < n-1: i++ → ISSUE.
  - Else if d < n-1: d++, i=0 → ISSUE.
  - Else → DONE.
- **DONE**: done=1 for one cycle → IDLE.
- Index counters are 8-bit. No wrap occurs because n ≤ N_MAX ≤ 255.
- Totals per run:
  - Writes: n(n+1)/2.
  - Triples: (n³−n)/6.
- start while busy: ignored. matlen changes mid-run: ignored.
- Reset low mid-run: abort immediately. No further rw or rd_valid; the table contents are undefined.

## Timing
- Reset values:
  - busy, done, err, rd_valid, last_k, rw, winit: 0.
  - ir, kr, jr, iw, jw: 0.
  - State: IDLE.
- All outputs are registered.
- Start sampled in cycle 0:
  - busy=1 and the first INIT write in cycle 1.
  - done pulses in the cycle after the last WRITE; busy drops the cycle after done.
- Outside ISSUE: rd_valid=0 and last_k=0. Outside INIT/WRITE: rw=0 and winit=0.
- Each cell costs (j−i) handshake beats + LAT + 1 cycles.
- Error and n=0 runs: done=1 in cycle 1, with no rw and no rd_valid.

## Test plan
- n=3, LAT=2, rd_ready=1:
  - INIT writes (0,0),(1,1),(2,2) in cycles 1–3.
  - Triples (0,0,1),(1,1,2),(0,0,2),(0,1,2); last_k on the 1st, 2nd and 4th.
  - Writes (0,1)@7, (1,2)@11, (0,2)@16; done@17.
- n=1: one init write (0,0) in cycle 1, done in cycle 2, zero triples.
- n=0 → done in cycle 1, err=0. n=40 with N_MAX=32 → done and err in cycle 1, no writes.
- n=4, LAT=0, rd_ready toggling 1/0 every cycle:
  - ir/kr/jr held stable across stalls.
  - 10 triples accepted, 10 writes total.
  - Each WRITE occurs the cycle after its last_k handshake.
- Reset pulled low during ISSUE of n=5:
  - All outputs 0 asynchronously, IDLE.
  - A new start with n=2 then produces writes (0,0),(1,1),(0,1) and the single triple (0,0,1).
- start asserted again while busy with n=3: ignored, and the run matches the first scenario exactly.
